data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder on the far end of the pipelined core's memory-stage load/store interface.
- Accepts one word request at a time from the M stage and waits a fixed, parameterised number of cycles.
- It then commits the write or returns the read data, and pulses a ready.
- A combinational busy output drives the hazard unit so the pipeline stalls until the access completes.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 2.
- LATENCY, 2: wait cycles between acceptance and completion; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- MemReqM  in  1  access request from M stage.
- MemWriteM  in  1  1 = store, 0 = load; sampled with MemReqM.
- ByteEnM  in  4  store byte enables; bit i enables byte i (bits 8i+7:8i).
- ALUOutM  in  32  byte address.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data; registered.
- ReadyM  out  1  one-cycle completion pulse.
- ErrM  out  1  one-cycle misalignment error pulse, coincident with ReadyM.
- MemBusyM  out  1  stall request to the hazard unit; combinational.

Behaviour:
- States: IDLE, WAIT, DONE. A down-counter cnt has width clog2(LATENCY)+1.
- Reset (rst=0 at a clock edge):
  - state goes to IDLE; cnt, ReadDataM, ReadyM and ErrM go to 0.
  - Latched request registers are cleared.
  - RAM contents are NOT reset.
  - Reset mid-WAIT discards the pending store: no RAM write, no ReadyM.
- IDLE:
  - If MemReqM=1, latch addr, wdata, we and be; set cnt = LATENCY-1; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Inputs are ignored; the latched copy is used.
  - If cnt != 0, decrement cnt. If cnt == 0, perform the access at this edge and go to DONE.
- Access at the WAIT-to-DONE edge:
  - Word index = addr[clog2(DEPTH_WORDS)+1:2]. Upper address bits are ignored (wrap modulo DEPTH_WORDS).
  - Misaligned (addr[1:0] != 0): no RAM write; ReadDataM is loaded with 0; ErrM is set for DONE.
  - Store: write only the bytes enabled by be; ReadDataM holds its previous value.
  - Load: ReadDataM <= RAM[index].
- DONE:
  - ReadyM=1 for exactly this cycle, then go to IDLE unconditionally.
  - MemReqM is not sampled in DONE. The earliest next acceptance is the following IDLE cycle.
- Latency: a request accepted in cycle t has ReadyM=1 in cycle t+LATENCY+1. Back-to-back throughput is one access per LATENCY+2 cycles.
- MemBusyM = (state==IDLE & MemReqM) | (state==WAIT).
  - It is 0 in DONE, so the pipeline advances and W captures ReadDataM in the ReadyM cycle.
  - Requester contract: after the DONE cycle MemReqM reflects the next instruction (or is 0).
- ReadDataM holds its value until the next completed load, misaligned access or reset.
- Store with be=0000: completes normally with ReadyM, no RAM change, ErrM=0.
- ErrM and ReadyM are never high outside DONE.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic [1:0] mem_state_t {IDLE, WAIT, DONE};
  - localparam WORD_BYTES = 4.
  - A function that returns the word index from an address and DEPTH_WORDS.
- Sub-module dmem_array:
  - Single-port synchronous RAM, 32-bit words, 4 byte-write enables, registered read, no reset.
  - data_mem_responder holds the FSM, counter, request latch, busy/ready/err logic and the ReadDataM register.

Test Plan:
- Reset with LATENCY=2:
  - Stimulus: rst=0 for 2 cycles with MemReqM=1.
  - Response: ReadyM=ErrM=0, ReadDataM=0. MemBusyM=1 only after rst is released, since state is IDLE and MemReqM=1.
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10 with ByteEnM=1111, accepted cycle 0: MemBusyM=1 in cycles 0-2, ReadyM=1 in cycle 3.
  - Then load 0x10: ReadDataM=0xDEADBEEF in its ReadyM cycle.
- Byte enables:
  - Stimulus: store 0x11223344 to 0x20 with 1111, then store 0xAABBCCDD with 0101, then load 0x20.
  - Response: ReadDataM=0x11BB33DD.
- Misalignment:
  - Stimulus: store to 0x22, then load 0x20 (holding 0x11BB33DD), then load 0x21.
  - Response: the store gives ErrM=ReadyM=1 for one cycle; the 0x20 load returns 0x11BB33DD (RAM unchanged); the 0x21 load returns ReadDataM=0 with ErrM=1.
- Wrap-around, DEPTH_WORDS=256:
  - Stimulus: store 0x5 to 0x400, then load 0x0.
  - Response: ReadDataM=0x5.
- Reset mid-WAIT, LATENCY=4:
  - Stimulus: store 0xCAFEF00D to 0x30 (old value 0x12345678); pulse rst=0 in cycle 2.
  - Response: no ReadyM; a subsequent load of 0x30 returns 0x12345678.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the data-memory responder.
//   mem_state_t : responder FSM states (IDLE, WAIT, DONE)
//   WORD_BYTES  : bytes per memory word
//   wordIndex   : converts a byte address into a word index, wrapping modulo depth
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

    localparam int WORD_BYTES = 4;

    // Drops the byte offset and wraps the word number into the array.
    // depthWords must be a power of two.
    function automatic int unsigned wordIndex(input logic [31:0] addr,
                                              input int unsigned depthWords);
        return (addr / 32'(WORD_BYTES)) & 32'(depthWords - 1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM with per-byte write enables.
//   clk    : clock, rising edge
//   addr   : word index (shared by read and write)
//   we     : write strobe
//   byteEn : byte lanes to write, bit i covers bits 8i+7:8i
//   wdata  : write data
//   rdata  : registered read data (old contents on a same-cycle write)
// Contents are not reset.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      addr,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] byteEn,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (byteEn[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory behind the M-stage load/store port.
// Accepts one request, waits LATENCY cycles, performs the access, then pulses ReadyM.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   MemReqM    : access request
//   MemWriteM  : 1 = store, 0 = load (sampled with MemReqM)
//   ByteEnM    : store byte enables
//   ALUOutM    : byte address
//   WriteDataM : store data
//   ReadDataM  : registered load data, held until next load/misaligned access/reset
//   ReadyM     : one-cycle completion pulse
//   ErrM       : one-cycle misalignment pulse, coincident with ReadyM
//   MemBusyM   : combinational stall request to the hazard unit
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [3:0]  ByteEnM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        ReadyM,
    output logic        ErrM,
    output logic        MemBusyM
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY) + 1;

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addrQ;
    logic [31:0]      wdataQ;
    logic             weQ;
    logic [3:0]       beQ;

    logic [IDX_W-1:0] ramAddr;
    logic             ramWe;
    logic [31:0]      ramRdata;
    logic             accessNow;
    logic             misaligned;

    assign accessNow  = (state == WAIT) && (cnt == '0);
    assign misaligned = (addrQ[1:0] != 2'b00);

    // In IDLE the RAM address follows the live request so the read data is
    // already registered by the time the access edge comes round, even with
    // LATENCY=1. Afterwards the latched address keeps it stable.
    assign ramAddr = (state == IDLE) ? IDX_W'(wordIndex(ALUOutM, DEPTH_WORDS))
                                     : IDX_W'(wordIndex(addrQ, DEPTH_WORDS));

    // A reset landing on the access edge must still discard the store.
    assign ramWe = accessNow && weQ && !misaligned && rst;

    // Gated by rst so no stall is requested while the block is held in reset.
    assign MemBusyM = rst && (((state == IDLE) && MemReqM) || (state == WAIT));

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .addr  (ramAddr),
        .we    (ramWe),
        .byteEn(beQ),
        .wdata (wdataQ),
        .rdata (ramRdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ReadDataM <= '0;
            ReadyM    <= 1'b0;
            ErrM      <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            weQ       <= 1'b0;
            beQ       <= '0;
        end else begin
            ReadyM <= 1'b0;
            ErrM   <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemReqM) begin
                        addrQ  <= ALUOutM;
                        wdataQ <= WriteDataM;
                        weQ    <= MemWriteM;
                        beQ    <= ByteEnM;
                        cnt    <= CNT_W'(LATENCY - 1);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state  <= DONE;
                        ReadyM <= 1'b1;
                        if (misaligned) begin
                            ReadDataM <= '0;
                            ErrM      <= 1'b1;
                        end else if (!weQ) begin
                            ReadDataM <= ramRdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
